// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: holds init_rst while copying BOOT_WORDS ROM words to LOAD_BASE.
// Optional image checksum verification enabled by defining BOOT_CHECKSUM_EN.
module boot_loader_ctrl #(
    parameter int          DW         = 32,
    parameter int          ROM_AW     = 10,
    parameter int          BOOT_WORDS = 256,
    parameter logic [31:0] LOAD_BASE  = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              reboot_req,
    output logic              rom_req,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DW-1:0]     rom_rdata,
    input  logic              rom_valid,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [31:0]       mem_waddr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb,
    output logic              init_rst,
    output logic              boot_done,
    output logic              boot_err
);

    typedef enum logic [2:0] {
        S_RD, S_WAIT, S_WR, S_DONE
`ifdef BOOT_CHECKSUM_EN
        , S_CHK_RD, S_CHK_WAIT, S_ERR
`endif
    } state_t;

    localparam logic [31:0] LAST_IDX = 32'(BOOT_WORDS - 1);

    state_t        state, state_n;
    logic [31:0]   idx, idx_n;
    logic [DW-1:0] data_buf, buf_n;
    logic          rd_strobe;

`ifdef BOOT_CHECKSUM_EN
    localparam logic [ROM_AW-1:0] CHK_ADDR = ROM_AW'(BOOT_WORDS);
    logic [DW-1:0] sum, sum_n;
    logic          chk_sel;
`endif

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        buf_n      = data_buf;
        rd_strobe  = 1'b0;
        mem_wvalid = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_n      = sum;
        chk_sel    = 1'b0;
`endif
        case (state)
            S_RD: begin
                rd_strobe = 1'b1;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                if (rom_valid) begin
                    buf_n   = rom_rdata;
`ifdef BOOT_CHECKSUM_EN
                    sum_n   = sum + rom_rdata;
`endif
                    state_n = S_WR;
                end
            end
            S_WR: begin
                mem_wvalid = 1'b1;
                if (mem_wready) begin
                    if (idx == LAST_IDX) begin
`ifdef BOOT_CHECKSUM_EN
                        state_n = S_CHK_RD;
`else
                        state_n = S_DONE;
`endif
                    end else begin
                        idx_n   = idx + 32'd1;
                        state_n = S_RD;
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHK_RD: begin
                rd_strobe = 1'b1;
                chk_sel   = 1'b1;
                state_n   = S_CHK_WAIT;
            end
            S_CHK_WAIT: begin
                if (rom_valid) state_n = (rom_rdata == sum) ? S_DONE : S_ERR;
            end
            S_ERR: begin
                if (reboot_req) begin
                    state_n = S_RD;
                    idx_n   = '0;
                    sum_n   = '0;
                end
            end
`endif
            S_DONE: begin
                if (reboot_req) begin
                    state_n = S_RD;
                    idx_n   = '0;
`ifdef BOOT_CHECKSUM_EN
                    sum_n   = '0;
`endif
                end
            end
            default: state_n = S_RD;
        endcase
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state     <= S_RD;
            idx       <= '0;
            data_buf  <= '0;
            init_rst  <= 1'b1;
            boot_done <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            data_buf  <= buf_n;
            init_rst  <= (state_n != S_DONE);
            boot_done <= (state_n == S_DONE);
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            sum      <= '0;
            boot_err <= 1'b0;
        end else begin
            sum      <= sum_n;
            boot_err <= (state_n == S_ERR);
        end
    end

    assign rom_addr = chk_sel ? CHK_ADDR : idx[ROM_AW-1:0];
`else
    assign boot_err = 1'b0;
    assign rom_addr = idx[ROM_AW-1:0];
`endif

    // Reset state is RD, so the strobe is masked while reset is held and
    // rises in the very first cycle after release.
    assign rom_req   = rd_strobe & global_rst_n;
    assign mem_waddr = LOAD_BASE + {idx[29:0], 2'b00};
    assign mem_wdata = data_buf;
    assign mem_wstrb = '1;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl with a 4-word image, random ROM
// latency, spurious rom_valid pulses and write back-pressure.
module tb_boot_loader_ctrl;

    localparam int          BW     = 4;
    localparam int          ROM_AW = 10;
    localparam int          DW     = 32;
    localparam logic [31:0] BASE   = 32'h8000_0000;
`ifdef BOOT_CHECKSUM_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic              clk;
    logic              global_rst_n;
    logic              reboot_req;
    logic              rom_req;
    logic [ROM_AW-1:0] rom_addr;
    logic [DW-1:0]     rom_rdata;
    logic              rom_valid;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [31:0]       mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic              init_rst;
    logic              boot_done;
    logic              boot_err;

    boot_loader_ctrl #(
        .DW(DW), .ROM_AW(ROM_AW), .BOOT_WORDS(BW), .LOAD_BASE(BASE)
    ) dut (
        .clk(clk), .global_rst_n(global_rst_n), .reboot_req(reboot_req),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .rom_valid(rom_valid), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .init_rst(init_rst), .boot_done(boot_done), .boot_err(boot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ROM image; entry BW holds the checksum word
    logic [31:0] rom_img [0:7];
    int unsigned lat_min = 1, lat_max = 1;
    bit          spurious = 1'b0;

    initial begin
        int unsigned       cnt;
        logic [ROM_AW-1:0] a;
        cnt = 0; a = '0;
        rom_valid = 1'b0; rom_rdata = '0;
        forever begin
            @(negedge clk);
            rom_valid = 1'b0;
            if (!global_rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        rom_valid = 1'b1;
                        rom_rdata = rom_img[a[2:0]];
                    end
                end else if (spurious && $urandom_range(0, 2) == 0) begin
                    rom_valid = 1'b1;
                    rom_rdata = $urandom;
                end
                if (rom_req) begin
                    a   = rom_addr;
                    cnt = $urandom_range(lat_min, lat_max);
                end
            end
        end
    end

    // Memory side: write log, back-pressure and hold-stability checking
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          stall_word = -1;
    int          stall_left = 0;
    int unsigned ready_pct  = 100;

    initial begin
        logic [31:0] hold_a, hold_d;
        bit          holding;
        holding = 1'b0; hold_a = '0; hold_d = '0;
        mem_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_wvalid) begin
                if (holding) begin
                    check("wr_hold_addr", mem_waddr, hold_a);
                    check("wr_hold_data", mem_wdata, hold_d);
                end
                check("wr_under_reset", 32'(init_rst), 32'd1);
                if (wq_addr.size() == stall_word && stall_left > 0) begin
                    mem_wready = 1'b0;
                    stall_left--;
                end else begin
                    mem_wready = ($urandom_range(0, 99) < ready_pct);
                end
                if (mem_wready) begin
                    wq_addr.push_back(mem_waddr);
                    wq_data.push_back(mem_wdata);
                    holding = 1'b0;
                end else begin
                    holding = 1'b1;
                    hold_a  = mem_waddr;
                    hold_d  = mem_wdata;
                end
            end else begin
                mem_wready = 1'($urandom_range(0, 1));
                holding    = 1'b0;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1 global_rst_n = 1'b0;
        reboot_req = 1'b0;
        #1;
        check("rst_init_rst", 32'(init_rst), 32'd1);
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_boot_err", 32'(boot_err), 32'd0);
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_wvalid", 32'(mem_wvalid), 32'd0);
        check("rst_waddr", mem_waddr, BASE);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'hF);
        @(negedge clk);
        @(negedge clk);
        wq_addr.delete();
        wq_data.delete();
        @(posedge clk);
        #1 global_rst_n = 1'b1;
    endtask

    task automatic pulse_reboot();
        wq_addr.delete();
        wq_data.delete();
        @(posedge clk);
        #1 reboot_req = 1'b1;
        @(posedge clk);
        #1 reboot_req = 1'b0;
    endtask

    // Counts active edges until the core is released or an error is flagged
    task automatic wait_done(input int reboot_at, output int n);
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            reboot_req = (n == reboot_at);
            if (!init_rst || boot_err) break;
        end
        reboot_req = 1'b0;
        if (n >= 3000) check("load_timeout", 32'(init_rst), 32'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 32'(wq_addr.size()), 32'(BW));
        for (int i = 0; i < BW && i < wq_addr.size(); i++) begin
            check({tag, "_addr"}, wq_addr[i], BASE + 32'(4 * i));
            check({tag, "_data"}, wq_data[i], rom_img[i]);
        end
    endtask

    task automatic check_released(input string tag);
        check({tag, "_done"}, 32'(boot_done), 32'd1);
        check({tag, "_init_rst"}, 32'(init_rst), 32'd0);
        check({tag, "_err"}, 32'(boot_err), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] s;
        global_rst_n = 1'b0;
        reboot_req   = 1'b0;
        rom_img[0] = 32'h11; rom_img[1] = 32'h22; rom_img[2] = 32'h33; rom_img[3] = 32'h44;
        rom_img[4] = 32'hAA; rom_img[5] = '0; rom_img[6] = '0; rom_img[7] = '0;

        // Back-to-back load
        apply_reset();
        wait_done(-1, n);
        check("basic_cycles", 32'(n), 32'(3 * BW + EXTRA));
        check_released("basic");
        check_writes("basic");

        // Five-cycle stall on word 2
        stall_word = 2; stall_left = 5;
        apply_reset();
        wait_done(-1, n);
        check("stall_cycles", 32'(n), 32'(3 * BW + 5 + EXTRA));
        check_released("stall");
        check_writes("stall");
        stall_word = -1;

        // Reset after two writes aborts, then the load restarts at LOAD_BASE
        apply_reset();
        for (int i = 0; i < 200 && wq_addr.size() < 2; i++) @(negedge clk);
        check("abort_pre_writes", 32'(wq_addr.size()), 32'd2);
        apply_reset();
        wait_done(-1, n);
        check("abort_cycles", 32'(n), 32'(3 * BW + EXTRA));
        check_writes("abort");

        // Reboot from DONE reloads everything
        pulse_reboot();
        check("reboot_init_rst", 32'(init_rst), 32'd1);
        check("reboot_done_low", 32'(boot_done), 32'd0);
        wait_done(-1, n);
        check("reboot_cycles", 32'(n), 32'(3 * BW + EXTRA));
        check_released("reboot");
        check_writes("reboot");

        // A reboot pulse mid-load is ignored
        pulse_reboot();
        wait_done(5, n);
        check("midreboot_cycles", 32'(n), 32'(3 * BW + EXTRA));
        check_writes("midreboot");

`ifdef BOOT_CHECKSUM_EN
        rom_img[4] = 32'hAB;
        apply_reset();
        wait_done(-1, n);
        check("csum_bad_cycles", 32'(n), 32'(3 * BW + EXTRA));
        check("csum_bad_err", 32'(boot_err), 32'd1);
        check("csum_bad_init_rst", 32'(init_rst), 32'd1);
        check("csum_bad_done", 32'(boot_done), 32'd0);
        rom_img[4] = 32'hAA;
        pulse_reboot();
        check("csum_reboot_err_low", 32'(boot_err), 32'd0);
        wait_done(-1, n);
        check_released("csum_fix");
        check_writes("csum_fix");
`endif

        // Random image, ROM latency, spurious valids and back-pressure
        lat_min = 1; lat_max = 7; spurious = 1'b1; ready_pct = 60;
        for (int it = 0; it < 20; it++) begin
            bit corrupt;
            s = '0;
            for (int i = 0; i < BW; i++) begin
                rom_img[i] = $urandom;
                s += rom_img[i];
            end
            corrupt = ($urandom_range(0, 3) == 0);
            rom_img[4] = corrupt ? s ^ (32'd1 << $urandom_range(0, 31)) : s;
`ifndef BOOT_CHECKSUM_EN
            corrupt = 1'b0;
`endif
            apply_reset();
            wait_done(-1, n);
            check("rand_done", 32'(boot_done), 32'(!corrupt));
            check("rand_err", 32'(boot_err), 32'(corrupt));
            check("rand_init_rst", 32'(init_rst), 32'(corrupt));
            check_writes("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Boot sequencer that owns core reset release. After power-on reset, or on a reboot request, it holds `init_rst` high. While reset is held it copies a fixed-size boot image word by word from the boot ROM into main memory at `LOAD_BASE`, then drops `init_rst` so the core fetches from the loaded image. It sits between the global reset, the boot ROM port and a memory write port, and drives the core's reset input.

## Interface
- `DW`, 32: data word width; memory address width is also 32.
- `ROM_AW`, 10: boot ROM word-address width.
- `BOOT_WORDS`, 256: number of image words to copy. Must satisfy 1 ≤ `BOOT_WORDS` < 2^`ROM_AW`.
- `LOAD_BASE`, 32'h8000_0000: byte address of the first loaded word.

Ports:
- `clk` in 1: the single clock.
- `global_rst_n` in 1: asynchronous, active-low reset.
- `reboot_req` in 1: single-cycle request to re-run the load.
- `rom_req` out 1: read strobe, one cycle per read.
- `rom_addr` out `ROM_AW`: ROM word address.
- `rom_rdata` in `DW`: ROM read data.
- `rom_valid` in 1: `rom_rdata` is valid.
- `mem_wvalid` out 1: write request.
- `mem_wready` in 1: memory accepts the write.
- `mem_waddr` out 32: byte address of the write.
- `mem_wdata` out `DW`: write data.
- `mem_wstrb` out `DW/8`: write strobes; always all ones.
- `init_rst` out 1: active-high core reset.
- `boot_done` out 1: image loaded and core released.
- `boot_err` out 1: checksum failure (only with `BOOT_CHECKSUM_EN`).

## Operation
- States: RD, WAIT, WR, CHK_RD, CHK_WAIT, DONE, ERR. A 32-bit index `idx` and a data buffer `buf` hold the copy position and the word in flight.
- RD: drive `rom_req`=1 and `rom_addr`=`idx`; go to WAIT.
- WAIT: on `rom_valid`, capture `rom_rdata` into `buf` and go to WR. Stay in WAIT while `rom_valid`=0.
- WR: drive `mem_wvalid`=1, `mem_waddr`=`LOAD_BASE`+4·`idx` and `mem_wdata`=`buf`. These values stay stable until `mem_wready` is seen.
- On the WR handshake:
  - if `idx`=`BOOT_WORDS`−1, go to DONE (or to CHK_RD when `BOOT_CHECKSUM_EN` is defined);
  - otherwise increment `idx` and go to RD.
- DONE: `init_rst`=0 and `boot_done`=1.
- ERR: `init_rst`=1 and `boot_err`=1.
- `reboot_req` in DONE or ERR: next state RD, `idx`=0, checksum cleared, `init_rst`=1 and `boot_done`=`boot_err`=0 from the next cycle.
- `reboot_req` in any other state is ignored; it is not queued.
- `rom_valid` outside WAIT and CHK_WAIT is ignored.
- `mem_waddr` arithmetic is modulo 2^32.

## Timing
- Reset (asynchronous assert) values:
  - state=RD, `idx`=0;
  - `init_rst`=1, `boot_done`=0, `boot_err`=0;
  - `rom_req`=0, `mem_wvalid`=0, `rom_addr`=0, `mem_waddr`=`LOAD_BASE`, `mem_wdata`=0.
- First `rom_req` is asserted in the first cycle after `global_rst_n` deasserts.
- Minimum cost is 3 cycles per word (RD, WAIT with `rom_valid` present, WR with `mem_wready` present), so the minimum load time is 3·`BOOT_WORDS` cycles.
- `rom_valid` may arrive at the earliest in the cycle after `rom_req`. ROM latency is unbounded.
- `init_rst` falls and `boot_done` rises in the cycle after the final handshake edge (or after the checksum compare). Both are registered and glitch-free.
- Reset asserted mid-load aborts immediately: all outputs return to their reset values, and the load restarts from `idx`=0 after deassert.
- No memory write is issued while `init_rst`=0.

## Configuration
- Macro: `BOOT_CHECKSUM_EN`.
- Defined:
  - every word captured in WAIT is added into a 32-bit wrapping sum;
  - after the last write, CHK_RD issues `rom_req` with `rom_addr`=`BOOT_WORDS`, and CHK_WAIT captures the word on `rom_valid`;
  - if the word equals the sum, go to DONE; otherwise go to ERR, with `init_rst` held high.
- Undefined: CHK_RD, CHK_WAIT and ERR are absent, no sum logic is built, and `boot_err` is tied to 0.

## Test plan
- `BOOT_WORDS`=4, ROM = {0x11,0x22,0x33,0x44}, `rom_valid` one cycle after `rom_req`, `mem_wready`=1 → writes to 0x8000_0000/04/08/0C with matching data; `init_rst` falls exactly 12 cycles after reset deassert; `boot_done`=1.
- `mem_wready` held low for 5 cycles on word 2 → `mem_waddr`=0x8000_0008 and data stable throughout; exactly one handshake per word; total time 17 cycles.
- Reset asserted after 2 words have been written → `init_rst`=1 at once; after deassert, writes restart at 0x8000_0000.
- In DONE, pulse `reboot_req` → `init_rst`=1 next cycle and all 4 words are rewritten. A `reboot_req` pulsed during the load has no effect.
- `BOOT_CHECKSUM_EN`, ROM word 4 = 0xAA → DONE. ROM word 4 = 0xAB → ERR with `boot_err`=1 and `init_rst`=1, then `reboot_req` with a corrected ROM → DONE.
- Random ROM latency of 1–7 cycles with spurious `rom_valid` pulses in RD/WR → the data written matches the ROM image and the spurious pulses are ignored.
